// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the UART RX frame parser: state encoding, default SOF marker, checksum step.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_EMIT    = 3'd4
  } state_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // One step of the frame checksum: XOR accumulation over LEN and payload bytes.
  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_rx_frame_parser_if.sv
// Bundles the RX FIFO read port, the payload stream and the status pulses of the frame parser.
// Latency: n/a (wiring only).
// Backpressure: m_ready stalls the payload stream; fifo_empty stalls parsing.
interface uart_rx_frame_parser_if;

  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       frame_ok;
  logic       len_err;
  logic       chk_err;
  logic       timeout_err;
  logic       busy;

  // Parser side.
  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_rd_en, m_valid, m_data, m_last,
    output frame_ok, len_err, chk_err, timeout_err, busy
  );

  // Environment side: the RX FIFO and the payload consumer.
  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_last,
    input  frame_ok, len_err, chk_err, timeout_err, busy
  );

endinterface

// File: rtl/uart_frame_buf.sv
// Payload holding buffer: DEPTH x W register array, synchronous write, asynchronous read.
// Latency: write visible on read port the cycle after i_we; read is combinational.
// Backpressure: none; the parser sequences writes and reads.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Store one payload byte per accepted write; contents need no reset since reads follow writes.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Pops bytes from the RX FIFO, hunts SOF/LEN/payload/CHK frames, buffers good payload and streams it out.
// Latency: one byte per 2 clk from the FIFO; emission begins the cycle frame_ok pulses, one byte per handshake.
// Backpressure: m_ready low holds m_data/m_last; FIFO reads pause during emission. UART_FRAME_TIMEOUT_EN adds inter-byte timeout.
module uart_rx_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int         DATA_BITS      = 8,
  parameter int         MAX_PAYLOAD    = 16,
  parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input logic                    clk,
  input logic                    rst,
  uart_rx_frame_parser_if.master bus
);

  localparam int               IDX_W   = $clog2(MAX_PAYLOAD + 1);
  localparam int               BUF_AW  = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  if (DATA_BITS != 8 || MAX_PAYLOAD < 1 || MAX_PAYLOAD > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_rx_frame_parser: unsupported parameter set");
  end

  state_t               r_state, w_state_n;
  logic                 r_rd_pend;
  logic [IDX_W-1:0]     r_idx, w_idx_n;
  logic [IDX_W-1:0]     r_len, w_len_n;
  logic [7:0]           r_chk, w_chk_n;
  logic                 r_frame_ok, w_frame_ok_n;
  logic                 r_len_err, w_len_err_n;
  logic                 r_chk_err, w_chk_err_n;
  logic                 r_timeout_err, w_timeout_err_n;

  logic                 w_rd_en;
  logic                 w_arrive;
  logic [DATA_BITS-1:0] w_byte;
  logic                 w_we;
  logic                 w_emit;
  logic                 w_last;
  logic [IDX_W-1:0]     w_idx_inc;
  logic [7:0]           w_rdata;
  logic                 w_to_hit;

  // A byte "arrives" the cycle after a read strobe; only one read is ever outstanding.
  assign w_arrive  = r_rd_pend;
  assign w_byte    = bus.fifo_dout;
  assign w_rd_en   = !rst && !bus.fifo_empty && !r_rd_pend && (r_state != ST_EMIT);
  assign w_emit    = (r_state == ST_EMIT);
  assign w_last    = w_emit && (r_idx == (r_len - IDX_ONE));
  assign w_idx_inc = r_idx + IDX_ONE;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt, w_to_cnt_n;
  logic            w_in_frame;

  assign w_in_frame = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CHK);
  // A byte landing in the expiry cycle takes precedence over the abort.
  assign w_to_hit   = w_in_frame && !w_arrive && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Idle-cycle count inside a frame; cleared by any byte, by the abort itself and outside the frame.
  always_comb begin
    w_to_cnt_n = r_to_cnt + TO_W'(1);
    if (w_arrive || !w_in_frame || w_to_hit) begin
      w_to_cnt_n = '0;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= w_to_cnt_n;
    end
  end
`else
  assign w_to_hit = 1'b0;
`endif

  // Next-state, datapath and status pulse decode for the frame hunt/emit sequence.
  always_comb begin
    w_state_n       = r_state;
    w_idx_n         = r_idx;
    w_len_n         = r_len;
    w_chk_n         = r_chk;
    w_frame_ok_n    = 1'b0;
    w_len_err_n     = 1'b0;
    w_chk_err_n     = 1'b0;
    w_timeout_err_n = 1'b0;
    w_we            = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (w_arrive && (w_byte == SOF_BYTE)) begin
          w_state_n = ST_LEN;
        end
      end
      ST_LEN: begin
        if (w_arrive) begin
          if ((w_byte == '0) || (w_byte > DATA_BITS'(MAX_PAYLOAD))) begin
            w_len_err_n = 1'b1;
            w_state_n   = ST_HUNT;
          end else begin
            w_len_n   = w_byte[IDX_W-1:0];
            w_chk_n   = chk_update(8'h00, w_byte);
            w_idx_n   = '0;
            w_state_n = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        // SOF values here are ordinary payload bytes.
        if (w_arrive) begin
          w_we    = 1'b1;
          w_chk_n = chk_update(r_chk, w_byte);
          w_idx_n = w_idx_inc;
          if (w_idx_inc == r_len) begin
            w_state_n = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (w_arrive) begin
          w_idx_n = '0;
          if (w_byte == r_chk) begin
            w_frame_ok_n = 1'b1;
            w_state_n    = ST_EMIT;
          end else begin
            w_chk_err_n = 1'b1;
            w_state_n   = ST_HUNT;
          end
        end
      end
      ST_EMIT: begin
        if (bus.m_ready) begin
          if (w_last) begin
            w_idx_n   = '0;
            w_state_n = ST_HUNT;
          end else begin
            w_idx_n = w_idx_inc;
          end
        end
      end
      default: begin
        w_state_n = ST_HUNT;
      end
    endcase
    if (w_to_hit) begin
      w_state_n       = ST_HUNT;
      w_idx_n         = '0;
      w_timeout_err_n = 1'b1;
    end
  end

  // State, index, checksum, read-pending flag and registered status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_HUNT;
      r_rd_pend     <= 1'b0;
      r_idx         <= '0;
      r_len         <= '0;
      r_chk         <= '0;
      r_frame_ok    <= 1'b0;
      r_len_err     <= 1'b0;
      r_chk_err     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_rd_pend     <= w_rd_en;
      r_idx         <= w_idx_n;
      r_len         <= w_len_n;
      r_chk         <= w_chk_n;
      r_frame_ok    <= w_frame_ok_n;
      r_len_err     <= w_len_err_n;
      r_chk_err     <= w_chk_err_n;
      r_timeout_err <= w_timeout_err_n;
    end
  end

  uart_frame_buf #(
    .DEPTH (MAX_PAYLOAD),
    .AW    (BUF_AW),
    .W     (8)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_idx[BUF_AW-1:0]),
    .i_wdata (w_byte),
    .i_raddr (r_idx[BUF_AW-1:0]),
    .o_rdata (w_rdata)
  );

  assign bus.fifo_rd_en  = w_rd_en;
  assign bus.m_valid     = w_emit;
  assign bus.m_data      = w_rdata;
  assign bus.m_last      = w_last;
  assign bus.frame_ok    = r_frame_ok;
  assign bus.len_err     = r_len_err;
  assign bus.chk_err     = r_chk_err;
  assign bus.timeout_err = r_timeout_err;
  assign bus.busy        = (r_state != ST_HUNT);

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Bench for uart_rx_frame_parser: FIFO model feeds byte streams, a frame-level model predicts payload and events.
// Latency: n/a.
// Backpressure: m_ready driven fixed, toggling or random; FIFO feed rate randomised to create empty gaps.
module tb_uart_rx_frame_parser;

  localparam int         MAXP = 16;
  localparam logic [7:0] SOF  = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_frame_parser_if bus();

  uart_rx_frame_parser #(
    .DATA_BITS      (8),
    .MAX_PAYLOAD    (MAXP),
    .SOF_BYTE       (SOF),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] src_q[$];
  logic [7:0] fifo_q[$];
  logic [8:0] exp_pay_q[$];   // {last, data}
  int         exp_evt_q[$];   // 1 ok, 2 len_err, 3 chk_err, 4 timeout_err
  int         feed_pct = 100;
  int         rdy_mode = 0;   // 0 always ready, 1 toggle, 2 random, 3 never
  logic       rd_seen  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level reference: walk the byte stream and list the events and payload it must produce.
  task automatic model_stream(input logic [7:0] s[$]);
    int p;
    int len;
    logic [7:0] x;
    p = 0;
    while (p < s.size()) begin
      if (s[p] != SOF) begin
        p++;
        continue;
      end
      if (p + 1 >= s.size()) break;
      len = int'(s[p+1]);
      if (len == 0 || len > MAXP) begin
        exp_evt_q.push_back(2);
        p += 2;
        continue;
      end
      if (p + 2 + len >= s.size()) break;
      x = s[p+1];
      for (int i = 0; i < len; i++) x = x ^ s[p+2+i];
      if (s[p+2+len] == x) begin
        exp_evt_q.push_back(1);
        for (int i = 0; i < len; i++) exp_pay_q.push_back({(i == len - 1), s[p+2+i]});
      end else begin
        exp_evt_q.push_back(3);
      end
      p += 3 + len;
    end
  endtask

  task automatic send(input logic [7:0] s[$]);
    model_stream(s);
    foreach (s[i]) src_q.push_back(s[i]);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((src_q.size() != 0 || fifo_q.size() != 0 || exp_pay_q.size() != 0 ||
            exp_evt_q.size() != 0 || bus.busy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check({name, "_drain_timeout"}, (t >= 5000), 0);
    check({name, "_left_events"}, exp_evt_q.size(), 0);
  endtask

  // FIFO model: 1-cycle read latency, bytes trickle in from src_q at feed_pct percent per cycle.
  initial begin
    bus.fifo_empty = 1'b1;
    bus.fifo_dout  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rd_seen && fifo_q.size() > 0) bus.fifo_dout = fifo_q.pop_front();
      if (src_q.size() > 0 && $urandom_range(99) < feed_pct) fifo_q.push_back(src_q.pop_front());
      bus.fifo_empty = (fifo_q.size() == 0);
    end
  end

  initial forever begin
    @(negedge clk);
    rd_seen = bus.fifo_rd_en;
  end

  // Consumer ready pattern.
  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = !bus.m_ready;
        2:       bus.m_ready = 1'($urandom_range(1));
        default: bus.m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compare every presented payload byte and every status pulse against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.m_valid) begin
        if (exp_pay_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_m_valid: got data %0h last %0b, nothing expected", bus.m_data, bus.m_last);
        end else begin
          check("m_data", bus.m_data, exp_pay_q[0][7:0]);
          check("m_last", bus.m_last, exp_pay_q[0][8]);
          if (bus.m_ready) void'(exp_pay_q.pop_front());
        end
      end
      if (bus.frame_ok || bus.len_err || bus.chk_err || bus.timeout_err) begin
        int nev;
        int code;
        nev  = int'(bus.frame_ok) + int'(bus.len_err) + int'(bus.chk_err) + int'(bus.timeout_err);
        code = bus.frame_ok ? 1 : bus.len_err ? 2 : bus.chk_err ? 3 : 4;
        check("pulse_exclusive", nev, 1);
        if (exp_evt_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: got code %0d, nothing expected", code);
        end else begin
          check("event_code", code, exp_evt_q.pop_front());
        end
        if (code != 1) check("busy_after_error", bus.busy, 0);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] out_vec();
    return {bus.fifo_rd_en, bus.m_valid, bus.m_last, bus.frame_ok, bus.len_err,
            bus.chk_err, bus.timeout_err, bus.busy, 1'b0};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("outputs_in_reset", out_vec(), 9'h000);
    src_q.delete();
    fifo_q.delete();
    exp_pay_q.delete();
    exp_evt_q.delete();
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  logic [7:0] s[$];
  logic [7:0] frame1[$];

  initial begin
    frame1 = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 9'h000);
    check("reset_m_valid", bus.m_valid, 0);
    #2;
    rst = 1'b0;

    // Good frame, consumer always ready.
    rdy_mode = 0;
    send(frame1);
    drain("frame1");

    // Bad checksum.
    s = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
    send(s);
    drain("bad_chk");

    // LEN of zero and LEN above the limit, then a single-byte frame carrying the SOF value.
    s = {8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'h01, 8'hA5, 8'hA4};
    send(s);
    drain("len_err");

    // Garbage before a frame, consumer toggling ready.
    rdy_mode = 1;
    s = {8'h00, 8'hFF, 8'h5A};
    foreach (frame1[i]) s.push_back(frame1[i]);
    send(s);
    drain("garbage_toggle");
    rdy_mode = 0;

`ifdef UART_FRAME_TIMEOUT_EN
    // Partial frame then silence: timeout abort, later frame still parses.
    s = {8'hA5, 8'h02, 8'h11};
    foreach (s[i]) src_q.push_back(s[i]);
    exp_evt_q.push_back(4);
    drain("timeout");
    send(frame1);
    drain("after_timeout");
`endif

    // Reset while collecting payload.
    s = {8'hA5, 8'h03, 8'h11};
    foreach (s[i]) src_q.push_back(s[i]);
    for (int t = 0; t < 100 && (src_q.size() != 0 || fifo_q.size() != 0); t++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("busy_mid_payload", bus.busy, 1);
    do_reset();
    send(frame1);
    drain("after_rst_payload");

    // Reset while emitting with the consumer stalled.
    rdy_mode = 3;
    send(frame1);
    for (int t = 0; t < 200 && !bus.m_valid; t++) @(negedge clk);
    check("m_valid_stalled", bus.m_valid, 1);
    do_reset();
    check("m_valid_after_rst", bus.m_valid, 0);
    rdy_mode = 0;
    send(frame1);
    drain("after_rst_emit");

    // Randomised mixes of good, bad-length, bad-checksum frames and garbage.
    for (int b = 0; b < 8; b++) begin
      rdy_mode = $urandom_range(2);
      feed_pct = $urandom_range(30, 100);
      s.delete();
      for (int k = 0; k < 4; k++) begin
        int r;
        int len;
        logic [7:0] x;
        logic [7:0] v;
        r = $urandom_range(9);
        if (r < 2) begin
          for (int g = 0; g < $urandom_range(1, 3); g++) begin
            v = 8'($urandom);
            if (v == SOF) v = 8'h00;
            s.push_back(v);
          end
        end else if (r == 2) begin
          s.push_back(SOF);
          s.push_back($urandom_range(1) ? 8'h00 : 8'($urandom_range(MAXP + 1, 255)));
        end else begin
          len = (r == 9) ? MAXP : $urandom_range(1, MAXP);
          s.push_back(SOF);
          s.push_back(8'(len));
          x = 8'(len);
          for (int i = 0; i < len; i++) begin
            v = 8'($urandom);
            s.push_back(v);
            x = x ^ v;
          end
          if (r < 5) x = x ^ 8'($urandom_range(1, 255));
          s.push_back(x);
        end
      end
      send(s);
      drain("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
